car_alarm_multi: RTL

Parametrised successor of the single-door car alarm controller. It supervises N_DOORS door switches plus ignition and remote arm/disarm pulses. The block arms passively or by remote, applies an entry delay, and drives the siren for a bounded period. After the siren period it re-arms, and it gives up into a silenced state after MAX_TRIPS siren periods. It sits at the top of the alarm subsystem and replaces the separate driver/arm/timer glue with internal timers.

---
 rtl/car_alarm_multi.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/car_alarm_multi.sv
// Multi-door car alarm controller: passive/remote arming, entry delay,
// bounded siren periods with re-arm, and give-up into a silenced state.
module car_alarm_multi #(
  parameter int unsigned N_DOORS   = 4,
  parameter int unsigned TW        = 8,
  parameter int unsigned T_ARM     = 8,
  parameter int unsigned T_ENTRY   = 4,
  parameter int unsigned T_SIREN   = 16,
  parameter int unsigned MAX_TRIPS = 3,
  parameter int unsigned PASSIVE   = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ignicao,
  input  logic [N_DOORS-1:0] door,
  input  logic               remote_arm,
  input  logic               remote_disarm,
  output logic               alarme,
  output logic               armado,
  output logic [2:0]         estado,
  output logic [N_DOORS-1:0] door_log,
  output logic [3:0]         trips
);

  localparam int unsigned TRIPS_W   = 4;
  localparam int unsigned TRIPS_MAX = 15;

  typedef enum logic [2:0] {
    DESARMADO  = 3'd0,
    ARMADO     = 3'd1,
    ACIONAR    = 3'd2,
    ACIONADO   = 3'd3,
    SILENCIADO = 3'd4
  } state_e;

  localparam logic [TW-1:0] ARM_LAST   = TW'(T_ARM - 1);
  localparam logic [TW-1:0] ENTRY_LAST = TW'(T_ENTRY - 1);
  localparam logic [TW-1:0] SIREN_LAST = TW'(T_SIREN - 1);

  state_e               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [N_DOORS-1:0]   door_log_q, door_log_d;
  logic [TRIPS_W-1:0]   trips_q, trips_d;
  logic                 alarme_q, alarme_d;
  logic                 armado_q, armado_d;

  logic                 quiet;
  logic                 any_door;
  logic [TRIPS_W:0]     trips_plus;
  logic [TRIPS_W-1:0]   trips_sat;
  logic                 last_trip;

  // Input qualifiers and trip-count arithmetic shared by the FSM
  always_comb begin
    quiet      = !ignicao && (door == '0);
    any_door   = |door;
    trips_plus = {1'b0, trips_q} + (TRIPS_W+1)'(1);
    trips_sat  = (trips_q == TRIPS_W'(TRIPS_MAX)) ? trips_q : trips_plus[TRIPS_W-1:0];
    last_trip  = (trips_plus == (TRIPS_W+1)'(MAX_TRIPS));
  end

  // Next-state, timer, door log and trip counter
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    door_log_d = door_log_q;
    trips_d    = trips_q;

    // Doors seen open are accumulated in every armed state
    if (state_q != DESARMADO) begin
      door_log_d = door_log_q | door;
    end

    if (remote_disarm) begin
      // Remote disarm outranks everything except reset, including remote_arm
      state_d = DESARMADO;
      timer_d = '0;
      trips_d = '0;
    end else begin
      unique case (state_q)
        DESARMADO: begin
          timer_d = '0;
          if (remote_arm && quiet) begin
            state_d    = ARMADO;
            door_log_d = '0;
          end else if ((PASSIVE != 0) && quiet) begin
            if (timer_q == ARM_LAST) begin
              state_d    = ARMADO;
              door_log_d = '0;
            end else begin
              timer_d = timer_q + TW'(1);
            end
          end
        end

        ARMADO: begin
          // Ignition alone does not trigger; only doors gate entry
          timer_d = '0;
          if (any_door) begin
            state_d = ACIONAR;
          end
        end

        ACIONAR: begin
          if (ignicao) begin
            state_d = DESARMADO;
            timer_d = '0;
            trips_d = '0;
          end else if (timer_q == ENTRY_LAST) begin
            state_d = ACIONADO;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end

        ACIONADO: begin
          if (ignicao) begin
            state_d = DESARMADO;
            timer_d = '0;
            trips_d = '0;
          end else if (timer_q == SIREN_LAST) begin
            // End of a siren period: count it, then give up, re-arm or repeat
            timer_d = '0;
            trips_d = trips_sat;
            if (last_trip) begin
              state_d = SILENCIADO;
            end else if (!any_door) begin
              state_d = ARMADO;
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end

        SILENCIADO: begin
          timer_d = '0;
          if (ignicao) begin
            state_d = DESARMADO;
            trips_d = '0;
          end
        end

        default: begin
          // Unused codes recover to the disarmed state
          state_d = DESARMADO;
          timer_d = '0;
        end
      endcase
    end
  end

  // Output decode from the next state so the outputs track the state register
  always_comb begin
    alarme_d = (state_d == ACIONADO);
    armado_d = (state_d != DESARMADO);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= DESARMADO;
      timer_q    <= '0;
      door_log_q <= '0;
      trips_q    <= '0;
      alarme_q   <= 1'b0;
      armado_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      door_log_q <= door_log_d;
      trips_q    <= trips_d;
      alarme_q   <= alarme_d;
      armado_q   <= armado_d;
    end
  end

  assign alarme   = alarme_q;
  assign armado   = armado_q;
  assign estado   = state_q;
  assign door_log = door_log_q;
  assign trips    = trips_q;

endmodule
